alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_req_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared, single-op arithmetic unit.
// Build option ALU_DIV_ZERO_CHECK_EN: divide-by-zero is answered locally and never issued.
module alu_req_arbiter #(
    parameter int A_WIDTH     = 5,
    parameter int B_WIDTH     = 5,
    parameter int ARITH_WIDTH = 10,
    parameter int TMO_CYCLES  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ0_VALID,
    output logic                   REQ0_READY,
    input  logic [A_WIDTH-1:0]     REQ0_A,
    input  logic [B_WIDTH-1:0]     REQ0_B,
    input  logic [1:0]             REQ0_FUNC,
    input  logic                   REQ1_VALID,
    output logic                   REQ1_READY,
    input  logic [A_WIDTH-1:0]     REQ1_A,
    input  logic [B_WIDTH-1:0]     REQ1_B,
    input  logic [1:0]             REQ1_FUNC,
    output logic                   RSP0_VALID,
    input  logic                   RSP0_READY,
    output logic                   RSP1_VALID,
    input  logic                   RSP1_READY,
    output logic [ARITH_WIDTH-1:0] RSP_DATA,
    output logic                   RSP_CARRY,
    output logic                   RSP_ERR,
    output logic [A_WIDTH-1:0]     AU_A,
    output logic [B_WIDTH-1:0]     AU_B,
    output logic [1:0]             AU_FUNC,
    output logic                   AU_EN,
    input  logic [ARITH_WIDTH-1:0] AU_OUT,
    input  logic                   AU_CARRY,
    input  logic                   AU_FLAG
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state;
    logic                 last;
    logic                 gnt_id;
    logic                 au_act;
    logic [A_WIDTH-1:0]   op_a;
    logic [B_WIDTH-1:0]   op_b;
    logic [1:0]           op_func;
    logic [3:0]           wdog;

    logic                 gnt;
    logic                 accept;
    logic                 div0;
    logic                 rsp_hs;
    logic [A_WIDTH-1:0]   sel_a;
    logic [B_WIDTH-1:0]   sel_b;
    logic [1:0]           sel_func;

    // Requester 1 wins only when alone or when requester 0 was served last.
    assign gnt        = REQ1_VALID && (!REQ0_VALID || !last);
    assign REQ0_READY = RST && (state == IDLE) && !gnt;
    assign REQ1_READY = RST && (state == IDLE) && gnt;
    assign accept     = (REQ0_VALID && REQ0_READY) || (REQ1_VALID && REQ1_READY);

    assign sel_a    = gnt ? REQ1_A    : REQ0_A;
    assign sel_b    = gnt ? REQ1_B    : REQ0_B;
    assign sel_func = gnt ? REQ1_FUNC : REQ0_FUNC;

    assign rsp_hs = (RSP0_VALID && RSP0_READY) || (RSP1_VALID && RSP1_READY);

`ifdef ALU_DIV_ZERO_CHECK_EN
    assign div0 = (sel_func == 2'b11) && (sel_b == '0);
`else
    assign div0 = 1'b0;
`endif

    // Operands are only presented to the unit while an op is in ISSUE or WAIT.
    assign AU_A    = au_act ? op_a    : '0;
    assign AU_B    = au_act ? op_b    : '0;
    assign AU_FUNC = au_act ? op_func : '0;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            last       <= 1'b1;
            gnt_id     <= 1'b0;
            au_act     <= 1'b0;
            AU_EN      <= 1'b0;
            wdog       <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_func    <= '0;
            RSP0_VALID <= 1'b0;
            RSP1_VALID <= 1'b0;
            RSP_DATA   <= '0;
            RSP_CARRY  <= 1'b0;
            RSP_ERR    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_func <= sel_func;
                        gnt_id  <= gnt;
                        if (div0) begin
                            RSP_DATA   <= '1;
                            RSP_CARRY  <= 1'b0;
                            RSP_ERR    <= 1'b1;
                            RSP0_VALID <= !gnt;
                            RSP1_VALID <= gnt;
                            state      <= RESP;
                        end else begin
                            au_act <= 1'b1;
                            AU_EN  <= 1'b1;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    AU_EN <= 1'b0;
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A result on the last watchdog cycle still counts as a result.
                    if (AU_FLAG || (wdog == 4'(TMO_CYCLES - 1))) begin
                        au_act     <= 1'b0;
                        RSP_DATA   <= AU_FLAG ? AU_OUT : '0;
                        RSP_CARRY  <= AU_FLAG && AU_CARRY;
                        RSP_ERR    <= !AU_FLAG;
                        RSP0_VALID <= !gnt_id;
                        RSP1_VALID <= gnt_id;
                        state      <= RESP;
                    end else begin
                        wdog <= wdog + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        last       <= gnt_id;
                        RSP0_VALID <= 1'b0;
                        RSP1_VALID <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Random two-requester traffic against a transaction-level scoreboard, plus
// directed scenarios for latency, fairness, stalls, watchdog and reset abort.
`timescale 1ns/1ps
module tb_alu_req_arbiter;

    localparam int AW  = 5;
    localparam int BW  = 5;
    localparam int RW  = 10;
    localparam int TMO = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic [AW-1:0] REQ0_A = '0, REQ1_A = '0;
    logic [BW-1:0] REQ0_B = '0, REQ1_B = '0;
    logic [1:0]    REQ0_FUNC = '0, REQ1_FUNC = '0;
    logic          RSP0_READY = 1'b0, RSP1_READY = 1'b0;
    logic [RW-1:0] AU_OUT = '0;
    logic          AU_CARRY = 1'b0, AU_FLAG = 1'b0;
    logic          REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID;
    logic [RW-1:0] RSP_DATA;
    logic          RSP_CARRY, RSP_ERR, AU_EN;
    logic [AW-1:0] AU_A;
    logic [BW-1:0] AU_B;
    logic [1:0]    AU_FUNC;

    always #5 CLK = ~CLK;

    alu_req_arbiter #(.A_WIDTH(AW), .B_WIDTH(BW), .ARITH_WIDTH(RW), .TMO_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUNC(REQ0_FUNC),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUNC(REQ1_FUNC),
        .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
        .RSP_DATA(RSP_DATA), .RSP_CARRY(RSP_CARRY), .RSP_ERR(RSP_ERR),
        .AU_A(AU_A), .AU_B(AU_B), .AU_FUNC(AU_FUNC), .AU_EN(AU_EN),
        .AU_OUT(AU_OUT), .AU_CARRY(AU_CARRY), .AU_FLAG(AU_FLAG)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;

    // scoreboard: one transaction in flight, timed by its age in cycles since accept
    bit            m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, m_dz = 1'b0;
    int            m_age = 0, m_rsp = 0;
    logic [AW-1:0] m_a = '0;
    logic [BW-1:0] m_b = '0;
    logic [1:0]    m_f = '0;
    logic [RW-1:0] m_data = '0;
    bit            m_carry = 1'b0, m_err = 1'b0;

    // arithmetic unit environment: latency 0 means it never answers
    int            force_lat = -1, au_lat = 1, au_cd = 0, au_en_cnt = 0;
    logic [RW:0]   au_res = '0;
    bit            en_s = 1'b0;
    logic [AW-1:0] a_s = '0;
    logic [BW-1:0] b_s = '0;
    logic [1:0]    f_s = '0;

    int            obs_cyc[$];
    bit            obs_id[$];
    logic [RW-1:0] obs_data[$];
    bit            obs_err[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [RW:0] au_calc(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [1:0] f);
        case (f)
            2'd0:    return 11'(a) + 11'(b);
            2'd1:    return 11'(a) - 11'(b);
            2'd2:    return 11'(a) * 11'(b);
            default: return (b == '0) ? 11'h2AA : 11'(a / b);
        endcase
    endfunction

    task automatic clr_obs();
        obs_cyc.delete(); obs_id.delete(); obs_data.delete(); obs_err.delete();
        au_en_cnt = 0;
    endtask

    task automatic cycle();
        bit g, v0, v1, act, rv;
        logic [RW:0] r;
        @(negedge CLK);
        cyc++;
        if (m_busy) m_age++;
        v0 = REQ0_VALID;
        v1 = REQ1_VALID;
        g  = (v0 && v1) ? !m_last : v1;
        if (m_busy) begin
            chk("ready0_busy", REQ0_READY, 0);
            chk("ready1_busy", REQ1_READY, 0);
        end else if (v0 || v1) begin
            chk("ready0", REQ0_READY, !g);
            chk("ready1", REQ1_READY, g);
        end
        act = m_busy && m_age >= 1 && m_age < m_rsp;
        rv  = m_busy && m_age >= m_rsp;
        chk("au_en", AU_EN, m_busy && !m_dz && m_age == 1);
        chk("au_a", AU_A, act ? m_a : '0);
        chk("au_b", AU_B, act ? m_b : '0);
        chk("au_func", AU_FUNC, act ? m_f : '0);
        chk("rsp0_valid", RSP0_VALID, rv && !m_id);
        chk("rsp1_valid", RSP1_VALID, rv && m_id);
        if (rv) begin
            chk("rsp_data", RSP_DATA, m_data);
            chk("rsp_carry", RSP_CARRY, m_carry);
            chk("rsp_err", RSP_ERR, m_err);
        end
        if (AU_EN) au_en_cnt++;
        if ((RSP0_VALID && RSP0_READY) || (RSP1_VALID && RSP1_READY)) begin
            obs_cyc.push_back(cyc); obs_id.push_back(RSP1_VALID);
            obs_data.push_back(RSP_DATA); obs_err.push_back(RSP_ERR);
        end
        en_s = AU_EN; a_s = AU_A; b_s = AU_B; f_s = AU_FUNC;
        if (rv && (m_id ? RSP1_READY : RSP0_READY)) begin
            m_busy = 1'b0;
            m_last = m_id;
        end else if (!m_busy && (v0 || v1)) begin
            m_busy = 1'b1; m_age = 0; m_id = g;
            m_a = g ? REQ1_A : REQ0_A;
            m_b = g ? REQ1_B : REQ0_B;
            m_f = g ? REQ1_FUNC : REQ0_FUNC;
            au_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 6));
            m_dz = 1'b0;
`ifdef ALU_DIV_ZERO_CHECK_EN
            m_dz = (m_f == 2'b11) && (m_b == '0);
`endif
            if (m_dz) begin
                m_rsp = 1; m_data = '1; m_carry = 1'b0; m_err = 1'b1;
            end else if (au_lat == 0 || au_lat > TMO) begin
                m_rsp = 2 + TMO; m_data = '0; m_carry = 1'b0; m_err = 1'b1;
            end else begin
                r = au_calc(m_a, m_b, m_f);
                m_rsp = 2 + au_lat; m_data = r[RW-1:0]; m_carry = r[RW]; m_err = 1'b0;
            end
        end
        @(posedge CLK); #1;
        AU_FLAG = 1'b0;
        if (en_s) begin
            au_res = au_calc(a_s, b_s, f_s);
            if (au_lat == 1) begin
                AU_FLAG = 1'b1; AU_OUT = au_res[RW-1:0]; AU_CARRY = au_res[RW];
            end else begin
                au_cd = (au_lat > 1) ? au_lat - 1 : 0;
            end
        end else if (au_cd > 0) begin
            au_cd--;
            if (au_cd == 0) begin
                AU_FLAG = 1'b1; AU_OUT = au_res[RW-1:0]; AU_CARRY = au_res[RW];
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b0; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        @(posedge CLK); #1;
        AU_FLAG = 1'b0; au_cd = 0; en_s = 1'b0;
        @(negedge CLK);
        cyc++;
        chk("rst_ready0", REQ0_READY, 0);
        chk("rst_ready1", REQ1_READY, 0);
        chk("rst_au_en", AU_EN, 0);
        chk("rst_au_a", AU_A, 0);
        chk("rst_au_b", AU_B, 0);
        chk("rst_au_func", AU_FUNC, 0);
        chk("rst_rsp0", RSP0_VALID, 0);
        chk("rst_rsp1", RSP1_VALID, 0);
        chk("rst_data", RSP_DATA, 0);
        chk("rst_carry", RSP_CARRY, 0);
        chk("rst_err", RSP_ERR, 0);
        @(posedge CLK); #1;
        cyc++;
        RST = 1'b1; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        m_busy = 1'b0; m_last = 1'b1; m_age = 0;
    endtask

    task automatic req0(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [1:0] f);
        REQ0_VALID = 1'b1; REQ0_A = a; REQ0_B = b; REQ0_FUNC = f;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        do_reset();

        // mul 7*9 with a one-cycle unit
        clr_obs(); force_lat = 1; RSP0_READY = 1'b1; c0 = cyc + 1;
        req0(7, 9, 2'b10);
        cycle(); REQ0_VALID = 1'b0;
        repeat (5) cycle();
        chk("d_mul_n", obs_id.size(), 1);
        if (obs_id.size() == 1) begin
            chk("d_mul_id", obs_id[0], 0);
            chk("d_mul_lat", obs_cyc[0] - c0, 3);
            chk("d_mul_data", obs_data[0], 63);
            chk("d_mul_err", obs_err[0], 0);
        end
        chk("d_mul_en", au_en_cnt, 1);

        // both requesters continuously valid: strict alternation, 4 cycles apart
        do_reset();
        clr_obs(); RSP0_READY = 1'b1; RSP1_READY = 1'b1;
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        REQ0_A = 3; REQ0_B = 4; REQ0_FUNC = 0; REQ1_A = 9; REQ1_B = 2; REQ1_FUNC = 1;
        repeat (17) cycle();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        repeat (5) cycle();
        chk("d_rr_n", obs_id.size() >= 4, 1);
        if (obs_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("d_rr_id", obs_id[i], i % 2);
            for (int i = 1; i < 4; i++) chk("d_rr_gap", obs_cyc[i] - obs_cyc[i-1], 4);
        end

        // silent unit: watchdog answers with an error after TMO wait cycles
        clr_obs(); force_lat = 0; c0 = cyc + 1;
        req0(5, 6, 2'b00);
        cycle(); REQ0_VALID = 1'b0;
        repeat (8) cycle();
        chk("d_tmo_n", obs_id.size(), 1);
        if (obs_id.size() == 1) begin
            chk("d_tmo_lat", obs_cyc[0] - c0, 2 + TMO);
            chk("d_tmo_err", obs_err[0], 1);
            chk("d_tmo_data", obs_data[0], 0);
        end

        // response back-pressure: nothing else moves while RESP is held
        force_lat = 1; RSP0_READY = 1'b0; RSP1_READY = 1'b1;
        req0(3, 4, 2'b10);
        cycle(); REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b1; REQ1_A = 2; REQ1_B = 9; REQ1_FUNC = 1;
        repeat (3) cycle();
        au_en_cnt = 0;
        repeat (5) cycle();
        chk("d_bp_en", au_en_cnt, 0);
        chk("d_bp_valid", RSP0_VALID, 1);
        chk("d_bp_data", RSP_DATA, 12);
        RSP0_READY = 1'b1;
        cycle(); cycle(); REQ1_VALID = 1'b0;
        repeat (5) cycle();

        // reset while waiting aborts silently; the next request is served normally
        clr_obs(); force_lat = 0;
        req0(1, 1, 2'b00);
        cycle(); REQ0_VALID = 1'b0;
        repeat (3) cycle();
        do_reset();
        force_lat = 1; RSP0_READY = 1'b1;
        req0(6, 5, 2'b10);
        cycle(); REQ0_VALID = 1'b0;
        repeat (5) cycle();
        chk("d_abort_n", obs_id.size(), 1);
        if (obs_id.size() == 1) chk("d_abort_data", obs_data[0], 30);

        // divide by zero
        clr_obs(); force_lat = 1; c0 = cyc + 1;
        req0(12, 0, 2'b11);
        cycle(); REQ0_VALID = 1'b0;
        repeat (5) cycle();
        chk("d_div0_n", obs_id.size(), 1);
`ifdef ALU_DIV_ZERO_CHECK_EN
        chk("d_div0_en", au_en_cnt, 0);
        if (obs_id.size() == 1) begin
            chk("d_div0_data", obs_data[0], 10'h3FF);
            chk("d_div0_err", obs_err[0], 1);
            chk("d_div0_lat", obs_cyc[0] - c0, 1);
        end
`else
        chk("d_div0_en", au_en_cnt, 1);
        if (obs_id.size() == 1) begin
            chk("d_div0_data", obs_data[0], 10'h2AA);
            chk("d_div0_err", obs_err[0], 0);
        end
`endif

        // random traffic, random unit latency and back-pressure, rare resets
        force_lat = -1;
        repeat (1500) begin
            REQ0_VALID = ($urandom_range(0, 9) < 6);
            REQ1_VALID = ($urandom_range(0, 9) < 6);
            REQ0_A = AW'($urandom); REQ1_A = AW'($urandom);
            REQ0_B = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom);
            REQ1_B = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom);
            REQ0_FUNC = 2'($urandom); REQ1_FUNC = 2'($urandom);
            RSP0_READY = ($urandom_range(0, 9) < 7);
            RSP1_READY = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
